// File: rtl/cp0_tlb_ctrl.sv
// CP0-side TLB maintenance controller: holds Index/Random/Wired/EntryHi/EntryLo0/1/BadVAddr
// and sequences TLBP/TLBR/TLBWI/TLBWR against the mmu TLB ports.
module cp0_tlb_ctrl #(
    parameter int unsigned TLB_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    input  logic [1:0]           op_code,
    output logic                 op_ready,
    output logic                 op_done,
    input  logic                 mtc0_we,
    input  logic [2:0]           mtc0_sel,
    input  logic [31:0]          mtc0_data,
    input  logic                 exc_tlb,
    input  logic [31:0]          exc_vaddr,
    output logic [31:0]          index_o,
    output logic [31:0]          random_o,
    output logic [31:0]          wired_o,
    output logic [31:0]          entry_lo0_o,
    output logic [31:0]          entry_lo1_o,
    output logic [31:0]          entry_hi_o,
    output logic [31:0]          badvaddr_o,
    output logic [7:0]           asid,
    output logic [85:0]          tlb_config,
    output logic [TLB_WIDTH-1:0] tlb_we_index,
    output logic                 tlb_we,
    output logic                 tlb_p,
    input  logic [31:0]          tlb_p_res_o,
    output logic [TLB_WIDTH-1:0] tlb_read_index,
    input  logic [85:0]          tlb_read_config_o
);

    localparam int unsigned TLB_NUM  = 1 << TLB_WIDTH;
    localparam int unsigned VPN2_W   = 19;
    localparam int unsigned ASID_W   = 8;
    localparam int unsigned LO_W     = 30;
    localparam logic [TLB_WIDTH-1:0] RAND_TOP = TLB_WIDTH'(TLB_NUM - 1);

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    localparam logic [2:0] SEL_INDEX = 3'd0;
    localparam logic [2:0] SEL_LO0   = 3'd2;
    localparam logic [2:0] SEL_LO1   = 3'd3;
    localparam logic [2:0] SEL_WIRED = 3'd4;
    localparam logic [2:0] SEL_HI    = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_READ  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   phase_q, phase_d;

    logic                 index_p_q,   index_p_d;
    logic [TLB_WIDTH-1:0] index_idx_q, index_idx_d;
    logic [TLB_WIDTH-1:0] random_q,    random_d;
    logic [TLB_WIDTH-1:0] wired_q,     wired_d;
    logic [TLB_WIDTH-1:0] we_idx_q,    we_idx_d;
    logic [LO_W-1:0]      lo0_q,       lo0_d;
    logic [LO_W-1:0]      lo1_q,       lo1_d;
    logic [VPN2_W-1:0]    vpn2_q,      vpn2_d;
    logic [ASID_W-1:0]    asid_q,      asid_d;
    logic [31:0]          badvaddr_q,  badvaddr_d;

    logic abort_c;
    logic accept_c;
    logic probe_done_c;
    logic read_done_c;
    logic unused_c;

    assign abort_c  = rst | exc_tlb;
    assign accept_c = op_ready & op_valid;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // FSM next state; PROBE/READ use phase 0 to launch and phase 1 to complete
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        unique case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    phase_d = 1'b0;
                    unique case (op_code)
                        OP_TLBP:  state_d = S_PROBE;
                        OP_TLBR:  state_d = S_READ;
                        default:  state_d = S_WRITE;
                    endcase
                end
            end
            S_PROBE, S_READ: begin
                if (phase_q) begin
                    state_d = S_IDLE;
                    phase_d = 1'b0;
                end else begin
                    phase_d = 1'b1;
                end
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (exc_tlb && state_q != S_IDLE) begin
            state_d = S_IDLE;
            phase_d = 1'b0;
        end
    end

    // FSM outputs; strobes are suppressed by a committed fault or reset
    always_comb begin
        op_ready     = 1'b0;
        tlb_p        = 1'b0;
        tlb_we       = 1'b0;
        probe_done_c = 1'b0;
        read_done_c  = 1'b0;
        unique case (state_q)
            S_IDLE:  op_ready = 1'b1;
            S_PROBE: begin
                tlb_p        = ~phase_q & ~abort_c;
                probe_done_c = phase_q & ~abort_c;
            end
            S_READ:  read_done_c = phase_q & ~abort_c;
            S_WRITE: tlb_we = ~abort_c;
            default: ;
        endcase
        op_done = probe_done_c | read_done_c | tlb_we;
    end

    // CP0 register next state: exc_tlb > op completion > mtc0
    always_comb begin
        index_p_d   = index_p_q;
        index_idx_d = index_idx_q;
        wired_d     = wired_q;
        we_idx_d    = we_idx_q;
        lo0_d       = lo0_q;
        lo1_d       = lo1_q;
        vpn2_d      = vpn2_q;
        asid_d      = asid_q;
        badvaddr_d  = badvaddr_q;

        if (mtc0_we && mtc0_sel == SEL_WIRED) begin
            wired_d  = mtc0_data[TLB_WIDTH-1:0];
            random_d = RAND_TOP;
        end else if (random_q <= wired_q) begin
            random_d = RAND_TOP;
        end else begin
            random_d = random_q - TLB_WIDTH'(1);
        end

        if (accept_c && op_code[1]) begin
            we_idx_d = (op_code == OP_TLBWR) ? random_q : index_idx_q;
        end

        if (probe_done_c) begin
            index_p_d = tlb_p_res_o[31];
            if (!tlb_p_res_o[31]) begin
                index_idx_d = tlb_p_res_o[TLB_WIDTH-1:0];
            end
        end else if (mtc0_we && mtc0_sel == SEL_INDEX) begin
            index_idx_d = mtc0_data[TLB_WIDTH-1:0];
        end

        if (exc_tlb) begin
            badvaddr_d = exc_vaddr;
            vpn2_d     = exc_vaddr[31:13];
        end else if (read_done_c) begin
            vpn2_d = tlb_read_config_o[85:67];
            asid_d = tlb_read_config_o[66:59];
            lo0_d  = {tlb_read_config_o[57:29], tlb_read_config_o[58]};
            lo1_d  = {tlb_read_config_o[28:0],  tlb_read_config_o[58]};
        end else if (mtc0_we) begin
            unique case (mtc0_sel)
                SEL_LO0: lo0_d = mtc0_data[LO_W-1:0];
                SEL_LO1: lo1_d = mtc0_data[LO_W-1:0];
                SEL_HI: begin
                    vpn2_d = mtc0_data[31:13];
                    asid_d = mtc0_data[7:0];
                end
                default: ;
            endcase
        end
    end

    // CP0 register state
    always_ff @(posedge clk) begin
        if (rst) begin
            index_p_q   <= 1'b0;
            index_idx_q <= '0;
            random_q    <= RAND_TOP;
            wired_q     <= '0;
            we_idx_q    <= '0;
            lo0_q       <= '0;
            lo1_q       <= '0;
            vpn2_q      <= '0;
            asid_q      <= '0;
            badvaddr_q  <= '0;
        end else begin
            index_p_q   <= index_p_d;
            index_idx_q <= index_idx_d;
            random_q    <= random_d;
            wired_q     <= wired_d;
            we_idx_q    <= we_idx_d;
            lo0_q       <= lo0_d;
            lo1_q       <= lo1_d;
            vpn2_q      <= vpn2_d;
            asid_q      <= asid_d;
            badvaddr_q  <= badvaddr_d;
        end
    end

    assign index_o        = {index_p_q, {(31 - TLB_WIDTH){1'b0}}, index_idx_q};
    assign random_o       = 32'(random_q);
    assign wired_o        = 32'(wired_q);
    assign entry_lo0_o    = 32'(lo0_q);
    assign entry_lo1_o    = 32'(lo1_q);
    assign entry_hi_o     = {vpn2_q, 5'b0, asid_q};
    assign badvaddr_o     = badvaddr_q;
    assign asid           = asid_q;
    assign tlb_we_index   = we_idx_q;
    assign tlb_read_index = index_idx_q;

    // Entry image: G is global only when both halves agree
    assign tlb_config = {vpn2_q, asid_q, lo0_q[0] & lo1_q[0], lo0_q[29:1], lo1_q[29:1]};

    assign unused_c = ^{exc_vaddr[12:0], tlb_p_res_o[30:TLB_WIDTH]};

endmodule

// File: tb/tb_cp0_tlb_ctrl.sv
// Directed bench for cp0_tlb_ctrl with a TLB stub and an expectation queue drained on op_done.
module tb_cp0_tlb_ctrl;

    localparam int unsigned TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          op_valid;
    logic [1:0]    op_code;
    logic          op_ready, op_done;
    logic          mtc0_we;
    logic [2:0]    mtc0_sel;
    logic [31:0]   mtc0_data;
    logic          exc_tlb;
    logic [31:0]   exc_vaddr;
    logic [31:0]   index_o, random_o, wired_o, entry_lo0_o, entry_lo1_o, entry_hi_o, badvaddr_o;
    logic [7:0]    asid;
    logic [85:0]   tlb_config;
    logic [TW-1:0] tlb_we_index, tlb_read_index;
    logic          tlb_we, tlb_p;
    logic [31:0]   tlb_p_res_o;
    logic [85:0]   tlb_read_config_o;

    logic [85:0]   tlb_mem [0:(1<<TW)-1];
    logic [31:0]   probe_val;

    always #5 clk = ~clk;

    cp0_tlb_ctrl #(.TLB_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .op_ready(op_ready), .op_done(op_done), .mtc0_we(mtc0_we),
        .mtc0_sel(mtc0_sel), .mtc0_data(mtc0_data), .exc_tlb(exc_tlb),
        .exc_vaddr(exc_vaddr), .index_o(index_o), .random_o(random_o),
        .wired_o(wired_o), .entry_lo0_o(entry_lo0_o), .entry_lo1_o(entry_lo1_o),
        .entry_hi_o(entry_hi_o), .badvaddr_o(badvaddr_o), .asid(asid),
        .tlb_config(tlb_config), .tlb_we_index(tlb_we_index), .tlb_we(tlb_we),
        .tlb_p(tlb_p), .tlb_p_res_o(tlb_p_res_o), .tlb_read_index(tlb_read_index),
        .tlb_read_config_o(tlb_read_config_o)
    );

    // TLB stub: registered read port, probe answer one cycle after tlb_p, write on tlb_we
    always @(posedge clk) begin
        tlb_read_config_o <= tlb_mem[tlb_read_index];
        if (tlb_p) tlb_p_res_o <= probe_val;
        if (tlb_we) tlb_mem[tlb_we_index] <= tlb_config;
    end

    typedef struct {
        string        tag;
        int unsigned  which;
        bit           after;
        logic [85:0]  val;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    localparam int unsigned W_INDEX = 0, W_HI = 1, W_LO0 = 2, W_LO1 = 3, W_BADV = 4,
                            W_WEIDX = 5, W_CFG = 6, W_WE = 7;

    function automatic logic [85:0] observe(input int unsigned which);
        case (which)
            W_INDEX: return 86'(index_o);
            W_HI:    return 86'(entry_hi_o);
            W_LO0:   return 86'(entry_lo0_o);
            W_LO1:   return 86'(entry_lo1_o);
            W_BADV:  return 86'(badvaddr_o);
            W_WEIDX: return 86'(tlb_we_index);
            W_CFG:   return tlb_config;
            W_WE:    return 86'(tlb_we);
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [85:0] obs, input logic [85:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int unsigned which, input bit after,
                        input logic [85:0] val);
        exp_t e;
        e.tag = tag; e.which = which; e.after = after; e.val = val;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [2:0] sel, input logic [31:0] data);
        mtc0_we = 1'b1; mtc0_sel = sel; mtc0_data = data;
        tick();
        mtc0_we = 1'b0;
    endtask

    // Issue an op, wait (bounded) for op_done, drain expectations at done and one cycle later
    task automatic run_op(input logic [1:0] code, input string tag, input int unsigned exp_lat);
        int unsigned lat;
        exp_t e;
        op_valid = 1'b1; op_code = code;
        tick();
        op_valid = 1'b0;
        if (code == 2'b00) check({tag, "_tlb_p"}, 86'(tlb_p), 86'(1));
        lat = 1;
        while (op_done !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        check({tag, "_done"}, 86'(op_done), 86'(1));
        check({tag, "_latency"}, 86'(lat), 86'(exp_lat));
        while (sb.size() > 0 && !sb[0].after) begin
            e = sb.pop_front();
            check(e.tag, observe(e.which), e.val);
        end
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.which), e.val);
        end
    endtask

    // Entry image built field by field from the values written in test 3
    localparam logic [85:0] CFG3 = {19'h00201, 8'h05, 1'b0,
                                    24'h000001, 3'd2, 1'b1, 1'b1,
                                    24'h000000, 3'd2, 1'b1, 1'b1};

    initial begin
        logic [TW-1:0] r_mdl;
        logic [TW-1:0] w_mdl;
        for (int i = 0; i < (1 << TW); i++) tlb_mem[i] = '0;
        rst = 1'b1; op_valid = 1'b0; op_code = '0; mtc0_we = 1'b0; mtc0_sel = '0;
        mtc0_data = '0; exc_tlb = 1'b0; exc_vaddr = '0; probe_val = '0;
        tlb_p_res_o = '0; tlb_read_config_o = '0;
        tick();
        tick();

        // Reset state
        check("rst_op_ready", 86'(op_ready), 86'(1));
        check("rst_op_done",  86'(op_done),  86'(0));
        check("rst_tlb_we",   86'(tlb_we),   86'(0));
        check("rst_tlb_p",    86'(tlb_p),    86'(0));
        check("rst_index",    86'(index_o),  86'(0));
        check("rst_random",   86'(random_o), 86'(15));
        check("rst_wired",    86'(wired_o),  86'(0));
        check("rst_entry_hi", 86'(entry_hi_o), 86'(0));
        check("rst_badvaddr", 86'(badvaddr_o), 86'(0));
        rst = 1'b0;

        // Random free-running with Wired=0
        r_mdl = 4'd15; w_mdl = 4'd0;
        for (int k = 0; k < 20; k++) begin
            check($sformatf("random_w0_%0d", k), 86'(random_o), 86'(r_mdl));
            check($sformatf("idle_we_%0d", k), 86'(tlb_we), 86'(0));
            tick();
            r_mdl = (r_mdl <= w_mdl) ? 4'd15 : r_mdl - 4'd1;
        end

        // Wired=4 forces Random to top, then it cycles 15..4
        mtc0(3'd4, 32'd4);
        r_mdl = 4'd15; w_mdl = 4'd4;
        for (int k = 0; k < 20; k++) begin
            check($sformatf("random_w4_%0d", k), 86'(random_o), 86'(r_mdl));
            tick();
            r_mdl = (r_mdl <= w_mdl) ? 4'd15 : r_mdl - 4'd1;
        end

        // Wired masked to index width
        mtc0(3'd4, 32'hFFFF_FFF6);
        check("wired_mask", 86'(wired_o), 86'(6));
        check("wired_forces_random", 86'(random_o), 86'(15));

        // TLBWR samples Random at accept
        mtc0(3'd4, 32'd4);
        push("tlbwr_we_index", W_WEIDX, 1'b0, 86'(15));
        push("tlbwr_we",       W_WE,    1'b0, 86'(1));
        push("tlbwr_we_off",   W_WE,    1'b1, 86'(0));
        run_op(2'b11, "tlbwr", 1);

        // mtc0 masking of unwritable bits
        mtc0(3'd5, 32'hFFFF_FFFF);
        check("hi_mask", 86'(entry_hi_o), 86'(32'hFFFF_E0FF));
        mtc0(3'd2, 32'hFFFF_FFFF);
        check("lo0_mask", 86'(entry_lo0_o), 86'(32'h3FFF_FFFF));
        mtc0(3'd0, 32'hFFFF_FFFF);
        check("index_mask", 86'(index_o), 86'(32'h0000_000F));

        // TLBWI with a known entry image
        mtc0(3'd5, 32'h0040_2005);
        mtc0(3'd2, 32'h0000_0056);
        mtc0(3'd3, 32'h0000_0017);
        mtc0(3'd0, 32'd3);
        check("hi_written",  86'(entry_hi_o),  86'(32'h0040_2005));
        check("lo1_written", 86'(entry_lo1_o), 86'(32'h0000_0017));
        check("asid_out",    86'(asid),        86'(8'h05));
        push("tlbwi_we_index", W_WEIDX, 1'b0, 86'(3));
        push("tlbwi_config",   W_CFG,   1'b0, CFG3);
        push("tlbwi_we",       W_WE,    1'b0, 86'(1));
        push("tlbwi_we_off",   W_WE,    1'b1, 86'(0));
        run_op(2'b10, "tlbwi", 1);
        check("stub_slot3", tlb_mem[3], CFG3);

        // TLBP hit, then miss keeps low bits
        mtc0(3'd0, 32'd7);
        probe_val = 32'h0000_0003;
        push("tlbp_hit_index", W_INDEX, 1'b1, 86'(32'h0000_0003));
        run_op(2'b00, "tlbp_hit", 2);
        probe_val = 32'h8000_0000;
        push("tlbp_miss_index", W_INDEX, 1'b1, 86'(32'h8000_0003));
        run_op(2'b00, "tlbp_miss", 2);

        // TLBR of slot 3; Lo1 returns with the combined G (0)
        mtc0(3'd5, 32'h0);
        mtc0(3'd2, 32'h0);
        mtc0(3'd3, 32'h0);
        push("tlbr_hi",  W_HI,  1'b1, 86'(32'h0040_2005));
        push("tlbr_lo0", W_LO0, 1'b1, 86'(32'h0000_0056));
        push("tlbr_lo1", W_LO1, 1'b1, 86'(32'h0000_0016));
        run_op(2'b01, "tlbr", 2);

        // Fault during WRITE: no strobe, slot untouched
        mtc0(3'd0, 32'd9);
        op_valid = 1'b1; op_code = 2'b10;
        tick();
        op_valid = 1'b0;
        exc_tlb = 1'b1; exc_vaddr = 32'hABCD_E000;
        #1;
        check("excw_tlb_we",  86'(tlb_we),  86'(0));
        check("excw_op_done", 86'(op_done), 86'(0));
        tick();
        exc_tlb = 1'b0;
        check("excw_ready",  86'(op_ready),   86'(1));
        check("excw_slot9",  tlb_mem[9],      86'(0));

        // Fault at TLBR completion cycle
        mtc0(3'd2, 32'h0);
        op_valid = 1'b1; op_code = 2'b01;
        tick();
        op_valid = 1'b0;
        tick();
        exc_tlb = 1'b1; exc_vaddr = 32'h1234_5678;
        #1;
        check("excr_op_done", 86'(op_done), 86'(0));
        tick();
        exc_tlb = 1'b0;
        check("excr_badvaddr", 86'(badvaddr_o), 86'(32'h1234_5678));
        check("excr_hi",       86'(entry_hi_o), 86'(32'h1234_4005));
        check("excr_lo0",      86'(entry_lo0_o), 86'(0));
        check("excr_ready",    86'(op_ready),   86'(1));
        tick();
        check("excr_no_late_done", 86'(op_done), 86'(0));

        // Reset in the middle of a probe
        probe_val = 32'h0000_0005;
        op_valid = 1'b1; op_code = 2'b00;
        tick();
        op_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid_tlb_p", 86'(tlb_p), 86'(0));
        tick();
        rst = 1'b0;
        check("rstmid_ready",   86'(op_ready), 86'(1));
        check("rstmid_done",    86'(op_done),  86'(0));
        check("rstmid_index",   86'(index_o),  86'(0));
        check("rstmid_random",  86'(random_o), 86'(15));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
